// File: rtl/traffic_light_sequencer_if.sv
// Timer bus between the intersection sequencer (master) and the down-counting light timer (slave).
// The timer reports only its zero flag back; everything else flows toward it.
interface traffic_light_sequencer_if #(
   parameter int N = 11
);
   logic         cnt_load;
   logic         cnt_en;
   logic         cnt_dir;
   logic [N-1:0] cnt_value;
   logic         cnt_switch;

   modport master (
      output cnt_load,
      output cnt_en,
      output cnt_dir,
      output cnt_value,
      input  cnt_switch
   );

   modport slave (
      input  cnt_load,
      input  cnt_en,
      input  cnt_dir,
      input  cnt_value,
      output cnt_switch
   );
endinterface

// File: rtl/traffic_light_sequencer.sv
// Intersection controller: steps main/side lamps through MG-MY-AR1-SG-SY-AR2, reloading the
// external down counter on every phase entry; maint forces a flashing-yellow mode.
module traffic_light_sequencer #(
   parameter int N    = 11,
   parameter int T_MG = 600,
   parameter int T_MY = 100,
   parameter int T_AR = 20,
   parameter int T_SG = 300,
   parameter int T_SY = 100,
   parameter int T_FL = 50
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       side_req,
   input  logic                       maint,
   traffic_light_sequencer_if.master  tmr,
   output logic [2:0]                 main_light,
   output logic [2:0]                 side_light,
   output logic [2:0]                 phase
);

   typedef enum logic [2:0] {
      S_MG    = 3'd0,
      S_MY    = 3'd1,
      S_AR1   = 3'd2,
      S_SG    = 3'd3,
      S_SY    = 3'd4,
      S_AR2   = 3'd5,
      S_FLASH = 3'd6
   } state_e;

   localparam logic [2:0] LAMP_R   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_G   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   // The timer spends one cycle loading and one cycle reporting zero, hence T-2.
   localparam logic [N-1:0] LD_MG = N'(T_MG - 2);
   localparam logic [N-1:0] LD_MY = N'(T_MY - 2);
   localparam logic [N-1:0] LD_AR = N'(T_AR - 2);
   localparam logic [N-1:0] LD_SG = N'(T_SG - 2);
   localparam logic [N-1:0] LD_SY = N'(T_SY - 2);
   localparam logic [N-1:0] LD_FL = N'(T_FL - 2);

   state_e state_q, state_d;
   logic   load_pend_q, load_pend_d;
   logic   flash_on_q, flash_on_d;
   logic   expiry;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_AR2;
         load_pend_q <= 1'b1;
         flash_on_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_pend_q <= load_pend_d;
         flash_on_q  <= flash_on_d;
      end
   end

   // In the load cycle the zero flag still belongs to the previous phase, so it is masked.
   assign expiry = tmr.cnt_switch & ~load_pend_q;

   always_comb begin
      state_d     = state_q;
      load_pend_d = 1'b0;
      flash_on_d  = flash_on_q;

      if (maint && (state_q != S_FLASH)) begin
         state_d     = S_FLASH;
         load_pend_d = 1'b1;
         flash_on_d  = 1'b1;
      end else if (expiry) begin
         unique case (state_q)
            S_MG: begin
               if (side_req) begin
                  state_d     = S_MY;
                  load_pend_d = 1'b1;
               end
            end
            S_MY: begin
               state_d     = S_AR1;
               load_pend_d = 1'b1;
            end
            S_AR1: begin
               state_d     = S_SG;
               load_pend_d = 1'b1;
            end
            S_SG: begin
               state_d     = S_SY;
               load_pend_d = 1'b1;
            end
            S_SY: begin
               state_d     = S_AR2;
               load_pend_d = 1'b1;
            end
            S_AR2: begin
               state_d     = S_MG;
               load_pend_d = 1'b1;
            end
            S_FLASH: begin
               load_pend_d = 1'b1;
               if (maint) begin
                  flash_on_d = ~flash_on_q;
               end else begin
                  state_d    = S_AR2;
                  flash_on_d = 1'b0;
               end
            end
            default: begin
               state_d     = S_AR2;
               load_pend_d = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      main_light    = LAMP_R;
      side_light    = LAMP_R;
      tmr.cnt_value = '0;

      unique case (state_q)
         S_MG: begin
            main_light = LAMP_G;
            if (load_pend_q) tmr.cnt_value = LD_MG;
         end
         S_MY: begin
            main_light = LAMP_Y;
            if (load_pend_q) tmr.cnt_value = LD_MY;
         end
         S_AR1, S_AR2: begin
            if (load_pend_q) tmr.cnt_value = LD_AR;
         end
         S_SG: begin
            side_light = LAMP_G;
            if (load_pend_q) tmr.cnt_value = LD_SG;
         end
         S_SY: begin
            side_light = LAMP_Y;
            if (load_pend_q) tmr.cnt_value = LD_SY;
         end
         S_FLASH: begin
            main_light = flash_on_q ? LAMP_Y : LAMP_OFF;
            side_light = flash_on_q ? LAMP_Y : LAMP_OFF;
            if (load_pend_q) tmr.cnt_value = LD_FL;
         end
         default: begin
            main_light = LAMP_R;
            side_light = LAMP_R;
         end
      endcase
   end

   // Enable drops at zero so the timer parks there instead of wrapping.
   assign tmr.cnt_load = load_pend_q;
   assign tmr.cnt_en   = ~load_pend_q & ~tmr.cnt_switch;
   assign tmr.cnt_dir  = 1'b1;
   assign phase        = state_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed and random bench for traffic_light_sequencer with a behavioural down counter as the timer.
// Expected per-cycle outputs are queued per phase and popped as the design steps through them.
module tb_traffic_light_sequencer;

   localparam logic [2:0] PH_MG = 3'd0, PH_MY = 3'd1, PH_AR1 = 3'd2, PH_SG = 3'd3,
                          PH_SY = 3'd4, PH_AR2 = 3'd5, PH_FL = 3'd6;
   localparam logic [2:0] L_R = 3'b100, L_Y = 3'b010, L_G = 3'b001;

   typedef struct packed {
      logic [2:0] ph;
      logic       ld;
      logic       en;
      logic [3:0] val;
      logic [2:0] ml;
      logic [2:0] sl;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       side_req;
   logic       maint;
   logic [2:0] main_light;
   logic [2:0] side_light;
   logic [2:0] phase;
   logic [3:0] tmr_value = 4'd0;

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   traffic_light_sequencer_if #(.N(4)) tmr_if ();

   traffic_light_sequencer #(
      .N(4), .T_MG(5), .T_MY(3), .T_AR(2), .T_SG(4), .T_SY(3), .T_FL(2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .side_req   (side_req),
      .maint      (maint),
      .tmr        (tmr_if),
      .main_light (main_light),
      .side_light (side_light),
      .phase      (phase)
   );

   always #5 clk = ~clk;

   // Light timer: parallel load has priority, otherwise count in the requested direction.
   always @(posedge clk) begin
      if (tmr_if.cnt_load === 1'b1)
         tmr_value <= tmr_if.cnt_value;
      else if (tmr_if.cnt_en === 1'b1)
         tmr_value <= (tmr_if.cnt_dir === 1'b1) ? tmr_value - 4'd1 : tmr_value + 4'd1;
   end
   assign tmr_if.cnt_switch = (tmr_value == 4'd0);

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic lampsFor(input logic [2:0] ph, input logic fl,
                           output logic [2:0] ml, output logic [2:0] sl);
      ml = L_R;
      sl = L_R;
      case (ph)
         PH_MG: ml = L_G;
         PH_MY: ml = L_Y;
         PH_SG: sl = L_G;
         PH_SY: sl = L_Y;
         PH_FL: begin
            ml = fl ? L_Y : 3'b000;
            sl = fl ? L_Y : 3'b000;
         end
         default: ;
      endcase
   endtask

   // Queue cycles start..start+cnt-1 of a phase lasting t cycles (indexes past t-1 are a hold at zero).
   task automatic pushPhase(input logic [2:0] ph, input int t, input int start, input int cnt,
                            input logic fl);
      exp_t e;
      for (int i = start; i < start + cnt; i++) begin
         e.ph  = ph;
         e.ld  = (i == 0);
         e.en  = (i >= 1) && (i <= t - 2);
         e.val = e.ld ? 4'(t - 2) : 4'd0;
         lampsFor(ph, fl, e.ml, e.sl);
         sb.push_back(e);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic m);
      rst_n    = r;
      side_req = s;
      maint    = m;
   endtask

   task automatic checkOutput(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 16'd1, 16'd0);
         end else begin
            e = sb.pop_front();
            chk("phase", 16'(phase), 16'(e.ph));
            chk("cnt_load", 16'(tmr_if.cnt_load), 16'(e.ld));
            chk("cnt_en", 16'(tmr_if.cnt_en), 16'(e.en));
            chk("cnt_value", 16'(tmr_if.cnt_value), 16'(e.val));
            chk("main_light", 16'(main_light), 16'(e.ml));
            chk("side_light", 16'(side_light), 16'(e.sl));
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic conflict;
      $display("[TB] start");
      applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_phase", 16'(phase), 16'(PH_AR2));
      chk("rst_load", 16'(tmr_if.cnt_load), 16'd1);
      chk("rst_value", 16'(tmr_if.cnt_value), 16'd0);
      chk("rst_dir", 16'(tmr_if.cnt_dir), 16'd1);
      chk("rst_main", 16'(main_light), 16'(L_R));
      chk("rst_side", 16'(side_light), 16'(L_R));

      $display("[TB] full phase cycle with side_req=1");
      applyStimulus(1'b1, 1'b1, 1'b0);
      pushPhase(PH_AR2, 2, 0, 2, 1'b0);
      pushPhase(PH_MG, 5, 0, 5, 1'b0);
      pushPhase(PH_MY, 3, 0, 3, 1'b0);
      pushPhase(PH_AR1, 2, 0, 2, 1'b0);
      pushPhase(PH_SG, 4, 0, 4, 1'b0);
      pushPhase(PH_SY, 3, 0, 3, 1'b0);
      pushPhase(PH_AR2, 2, 0, 2, 1'b0);
      pushPhase(PH_MG, 5, 0, 1, 1'b0);
      checkOutput(22);

      $display("[TB] main green hold without side request");
      applyStimulus(1'b1, 1'b0, 1'b0);
      pushPhase(PH_MG, 5, 1, 40, 1'b0);
      checkOutput(40);
      chk("hold_timer", 16'(tmr_value), 16'd0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      pushPhase(PH_MG, 5, 41, 1, 1'b0);
      pushPhase(PH_MY, 3, 0, 3, 1'b0);
      pushPhase(PH_AR1, 2, 0, 2, 1'b0);
      pushPhase(PH_SG, 4, 0, 2, 1'b0);
      checkOutput(8);

      $display("[TB] maintenance flash entered mid side green");
      applyStimulus(1'b1, 1'b1, 1'b1);
      pushPhase(PH_SG, 4, 2, 1, 1'b0);
      for (int k = 0; k < 4; k++) pushPhase(PH_FL, 2, 0, 2, (k % 2) == 0);
      checkOutput(9);
      applyStimulus(1'b1, 1'b1, 1'b0);
      pushPhase(PH_FL, 2, 0, 2, 1'b1);
      pushPhase(PH_AR2, 2, 0, 2, 1'b0);
      pushPhase(PH_MG, 5, 0, 1, 1'b0);
      checkOutput(5);

      $display("[TB] reset held mid main yellow");
      pushPhase(PH_MG, 5, 1, 4, 1'b0);
      pushPhase(PH_MY, 3, 0, 1, 1'b0);
      checkOutput(5);
      applyStimulus(1'b0, 1'b1, 1'b0);
      pushPhase(PH_MY, 3, 1, 1, 1'b0);
      pushPhase(PH_AR2, 2, 0, 1, 1'b0);
      pushPhase(PH_AR2, 2, 0, 1, 1'b0);
      checkOutput(3);
      applyStimulus(1'b1, 1'b1, 1'b0);
      pushPhase(PH_AR2, 2, 0, 2, 1'b0);
      pushPhase(PH_MG, 5, 0, 5, 1'b0);
      pushPhase(PH_MY, 3, 0, 3, 1'b0);
      pushPhase(PH_AR1, 2, 0, 2, 1'b0);
      pushPhase(PH_SG, 4, 0, 4, 1'b0);
      pushPhase(PH_SY, 3, 0, 2, 1'b0);
      checkOutput(18);

      $display("[TB] maint coincides with side yellow expiry");
      applyStimulus(1'b1, 1'b1, 1'b1);
      pushPhase(PH_SY, 3, 2, 1, 1'b0);
      checkOutput(1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      pushPhase(PH_FL, 2, 0, 2, 1'b1);
      pushPhase(PH_AR2, 2, 0, 2, 1'b0);
      pushPhase(PH_MG, 5, 0, 1, 1'b0);
      checkOutput(5);
      chk("sb_drained", 16'(sb.size()), 16'd0);

      $display("[TB] random side_req/maint run");
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
         @(posedge clk);
         #1;
         conflict = (phase != PH_FL) && (|main_light[1:0]) && (|side_light[1:0]);
         chk("lamp_conflict", 16'(conflict), 16'd0);
         chk("en_and_load", 16'(tmr_if.cnt_en & tmr_if.cnt_load), 16'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
